mc_control: RTL and testbench

Multicycle control unit for the single-memory MIPS core. It takes the `op`/`func` fields produced by the instruction decoder, plus the ALU `zero` flag and a memory-ready handshake. It sequences fetch, decode, execute, memory and write-back over several cycles by driving every mux select and write strobe of the shared datapath (PC, IR, register file, ALU, unified memory).

---
 rtl/mc_pkg.sv | 65 ++++++
 rtl/mc_alu_dec.sv | 36 +++
 rtl/mc_control.sv | 164 ++++++++++++++++
 tb/tb_mc_control.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes, func codes,
// ALU operations and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRex    = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StIex    = 4'd9,
    StIwb    = 4'd10,
    StJump   = 4'd11,
    StTrap   = 4'd12,
    StRst    = 4'd15
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSrl = 6'b000010;

  localparam logic [3:0] AluAdd = 4'd0;
  localparam logic [3:0] AluSub = 4'd1;
  localparam logic [3:0] AluAnd = 4'd2;
  localparam logic [3:0] AluOr  = 4'd3;
  localparam logic [3:0] AluSlt = 4'd4;
  localparam logic [3:0] AluSll = 4'd5;
  localparam logic [3:0] AluSrl = 4'd6;

  localparam logic [1:0] SrcAPc    = 2'd0;
  localparam logic [1:0] SrcAReg   = 2'd1;
  localparam logic [1:0] SrcAShamt = 2'd2;

  localparam logic [1:0] SrcBReg   = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBImmSh = 2'd3;

  localparam logic [1:0] PcAluRes = 2'd0;
  localparam logic [1:0] PcAluOut = 2'd1;
  localparam logic [1:0] PcJump   = 2'd2;

  function automatic logic is_shift(input logic [5:0] func);
    return (func == FnSll) || (func == FnSrl);
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU decoder: maps (op, func) to an ALU operation and flags
// encodings the core does not implement.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [3:0] alu_ctrl,
  output logic       legal
);

  always_comb begin
    alu_ctrl = AluAdd;
    legal    = 1'b1;
    case (op)
      OpRtype: begin
        case (func)
          FnAdd:   alu_ctrl = AluAdd;
          FnSub:   alu_ctrl = AluSub;
          FnAnd:   alu_ctrl = AluAnd;
          FnOr:    alu_ctrl = AluOr;
          FnSlt:   alu_ctrl = AluSlt;
          FnSll:   alu_ctrl = AluSll;
          FnSrl:   alu_ctrl = AluSrl;
          default: legal    = 1'b0;
        endcase
      end
      OpLw, OpSw, OpAddi, OpJ: alu_ctrl = AluAdd;
      OpBeq, OpBne:            alu_ctrl = AluSub;
      OpAndi:                  alu_ctrl = AluAnd;
      OpOri:                   alu_ctrl = AluOr;
      default:                 legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM for the single-memory MIPS core; drives every datapath
// select and write strobe from the current state plus op/func/zero/mem_ready.
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sign,
  output logic [3:0] alu_ctrl,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [3:0] dec_alu_ctrl;
  logic       dec_legal;

  mc_alu_dec u_alu_dec (
    .op       (op),
    .func     (func),
    .alu_ctrl (dec_alu_ctrl),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StRst:    state_d = StFetch;
      StFetch:  state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        if (!dec_legal) begin
          state_d = StTrap;
        end else begin
          case (op)
            OpLw, OpSw:             state_d = StMemAdr;
            OpRtype:                state_d = StRex;
            OpBeq, OpBne:           state_d = StBranch;
            OpAddi, OpAndi, OpOri:  state_d = StIex;
            OpJ:                    state_d = StJump;
            default:                state_d = StTrap;
          endcase
        end
      end
      StMemAdr: state_d = (op == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
      StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
      StRex:    state_d = StRwb;
      StIex:    state_d = StIwb;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBReg;
    ext_sign   = 1'b0;
    alu_ctrl   = AluAdd;
    pc_src     = PcAluRes;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = SrcBFour;
        pc_en     = mem_ready;
        ir_write  = mem_ready;
      end
      StDecode: begin
        alu_src_b = SrcBImmSh;
        ext_sign  = 1'b1;
      end
      StMemAdr: begin
        alu_src_a = SrcAReg;
        alu_src_b = SrcBImm;
        ext_sign  = 1'b1;
      end
      StMemRd: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      StMemWr: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      StRex: begin
        alu_src_a = is_shift(func) ? SrcAShamt : SrcAReg;
        alu_ctrl  = dec_alu_ctrl;
      end
      StRwb: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        alu_src_a  = SrcAReg;
        alu_ctrl   = AluSub;
        pc_src     = PcAluOut;
        pc_en      = (op == OpBeq) ? zero : !zero;
        instr_done = 1'b1;
      end
      StIex: begin
        alu_src_a = SrcAReg;
        alu_src_b = SrcBImm;
        alu_ctrl  = dec_alu_ctrl;
        ext_sign  = (op == OpAddi);
      end
      StIwb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StJump: begin
        pc_src     = PcJump;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      StTrap: begin
        illegal    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: a per-instruction phase-list model predicts
// every output each cycle, plus directed scenarios with literal expectations.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] func = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
  logic [1:0] alu_src_a, alu_src_b, pc_src;
  logic       ext_sign, instr_done, illegal;
  logic [3:0] alu_ctrl, state;

  mc_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .func       (func),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .ir_write   (ir_write),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_sign   (ext_sign),
    .alu_ctrl   (alu_ctrl),
    .pc_src     (pc_src),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       ext_sign;
    logic [3:0] alu;
    logic [1:0] pc_src;
    logic       done;
    logic       illegal;
    logic [3:0] state;
  } outs_t;

  outs_t dut_o;
  assign dut_o = {pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, ext_sign, alu_ctrl, pc_src, instr_done, illegal, state};

  int    vectors = 0;
  int    miscompares = 0;
  outs_t snap;

  // Model: each instruction is a list of phases; memory phases repeat while mem_ready=0.
  bit    m_rst = 1'b1;
  bit    need_new = 1'b0;
  int    plan[$];
  int    pidx = 0;

  function automatic bit r_legal(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000,
                     6'b000010};
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 4'd1;
      6'b100100: return 4'd2;
      6'b100101: return 4'd3;
      6'b101010: return 4'd4;
      6'b000000: return 4'd5;
      6'b000010: return 4'd6;
      default:   return 4'd0;
    endcase
  endfunction

  function automatic void make_plan(input logic [5:0] o, input logic [5:0] f);
    plan.delete();
    plan.push_back(0);
    plan.push_back(1);
    case (o)
      6'h23: begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
      6'h2b: begin plan.push_back(2); plan.push_back(5); end
      6'h00: begin
        if (r_legal(f)) begin plan.push_back(6); plan.push_back(7); end
        else plan.push_back(12);
      end
      6'h04, 6'h05: plan.push_back(8);
      6'h08, 6'h0c, 6'h0d: begin plan.push_back(9); plan.push_back(10); end
      6'h02: plan.push_back(11);
      default: plan.push_back(12);
    endcase
  endfunction

  function automatic int cur_phase();
    if (m_rst) return 15;
    if (need_new) return 0;
    return plan[pidx];
  endfunction

  function automatic outs_t exp_outs(input int ph, input logic [5:0] o, input logic [5:0] f,
                                     input logic z, input logic mr);
    outs_t e;
    e = '0;
    e.state = 4'(ph);
    case (ph)
      0:  begin e.mem_read = 1; e.src_b = 2'd1; e.pc_en = mr; e.ir_write = mr; end
      1:  begin e.src_b = 2'd3; e.ext_sign = 1; end
      2:  begin e.src_a = 2'd1; e.src_b = 2'd2; e.ext_sign = 1; end
      3:  begin e.iord = 1; e.mem_read = 1; end
      4:  begin e.reg_write = 1; e.mem_to_reg = 1; e.done = 1; end
      5:  begin e.iord = 1; e.mem_write = 1; e.done = mr; end
      6:  begin e.src_a = (f == 6'b000000 || f == 6'b000010) ? 2'd2 : 2'd1; e.alu = r_alu(f); end
      7:  begin e.reg_write = 1; e.reg_dst = 1; e.done = 1; end
      8:  begin
        e.src_a = 2'd1; e.alu = 4'd1; e.pc_src = 2'd1; e.done = 1;
        e.pc_en = (o == 6'h04) ? z : !z;
      end
      9:  begin
        e.src_a = 2'd1; e.src_b = 2'd2;
        if (o == 6'h08) e.ext_sign = 1;
        else if (o == 6'h0c) e.alu = 4'd2;
        else e.alu = 4'd3;
      end
      10: begin e.reg_write = 1; e.done = 1; end
      11: begin e.pc_src = 2'd2; e.pc_en = 1; e.done = 1; end
      12: begin e.illegal = 1; e.done = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic model_step();
    int ph;
    if (!rst_n) begin
      m_rst = 1'b1;
    end else if (m_rst) begin
      m_rst = 1'b0;
      need_new = 1'b1;
    end else begin
      ph = plan[pidx];
      if (!((ph == 0 || ph == 3 || ph == 5) && !mem_ready)) begin
        pidx++;
        if (pidx == plan.size()) begin
          pidx = 0;
          need_new = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic mr);
    outs_t e;
    @(negedge clk);
    rst_n = r; op = o; func = f; zero = z; mem_ready = mr;
    if (need_new && !m_rst) begin
      make_plan(o, f);
      pidx = 0;
      need_new = 1'b0;
    end
    #1;
    snap = dut_o;
    e = exp_outs(cur_phase(), o, f, z, mr);
    vectors++;
    if (snap !== e) begin
      miscompares++;
      $display("FAIL outs @%0t: got %h want %h", $time, snap, e);
    end
    @(posedge clk);
    model_step();
  endtask

  task automatic lit(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  int    seq[$];
  int    n_cyc, n_done, n_ill, n_wr, n_hold;
  outs_t last;

  // Runs one instruction with mem_ready low for `waits` cycles in its data-memory phase.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int waits);
    int  w;
    int  ph;
    logic mr;
    w = waits;
    seq.delete();
    n_cyc = 0; n_done = 0; n_ill = 0; n_wr = 0; n_hold = 0;
    do begin
      ph = cur_phase();
      mr = 1'b1;
      if ((ph == 3 || ph == 5) && w > 0) begin
        mr = 1'b0;
        w--;
      end
      cyc(1'b1, o, f, z, mr);
      n_cyc++;
      seq.push_back(int'(snap.state));
      if (snap.done) n_done++;
      if (snap.illegal) n_ill++;
      if (snap.reg_write || snap.mem_write) n_wr++;
      if (snap.state == 4'd3 && snap.iord && snap.mem_read) n_hold++;
      last = snap;
    end while (!snap.done && n_cyc < 20);
  endtask

  outs_t      tmp;
  logic [5:0] cur_op, cur_func;
  logic [5:0] ops[8] = '{6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h02};
  logic [5:0] fns[7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000,
                         6'b000010};

  initial begin
    @(posedge clk);
    repeat (3) begin
      cyc(1'b0, 6'h00, 6'h20, 1'b0, 1'b1);
      tmp = snap;
      tmp.state = '0;
      lit("rst_state", int'(snap.state), 15);
      lit("rst_outs_zero", int'(tmp), 0);
    end
    cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b1);
    lit("release_state", int'(snap.state), 15);

    run_instr(6'h00, 6'h20, 1'b0, 0);
    lit("add_cycles", n_cyc, 4);
    lit("add_seq0", seq[0], 0);
    lit("add_seq1", seq[1], 1);
    lit("add_seq2", seq[2], 6);
    lit("add_seq3", seq[3], 7);
    lit("add_wb", int'({last.reg_write, last.reg_dst}), 3);
    lit("add_done_cnt", n_done, 1);

    run_instr(6'h23, 6'h15, 1'b0, 2);
    lit("lw_cycles", n_cyc, 7);
    lit("lw_rd_hold", n_hold, 3);
    lit("lw_mem_to_reg", int'(last.mem_to_reg), 1);

    run_instr(6'h04, 6'h00, 1'b1, 0);
    lit("beq_cycles", n_cyc, 3);
    lit("beq_pc", int'({last.pc_en, last.pc_src}), 3'b101);
    run_instr(6'h05, 6'h00, 1'b1, 0);
    lit("bne_cycles", n_cyc, 3);
    lit("bne_pc_en", int'(last.pc_en), 0);

    run_instr(6'h3f, 6'h00, 1'b0, 0);
    lit("trap_cycles", n_cyc, 3);
    lit("trap_ill_cnt", n_ill, 1);
    lit("trap_no_write", n_wr, 0);
    run_instr(6'h00, 6'h01, 1'b0, 0);
    lit("rfunc_trap_state", seq[2], 12);

    cyc(1'b1, 6'h2b, 6'h00, 1'b0, 1'b1);
    cyc(1'b1, 6'h2b, 6'h00, 1'b0, 1'b1);
    cyc(1'b1, 6'h2b, 6'h00, 1'b0, 1'b1);
    cyc(1'b1, 6'h2b, 6'h00, 1'b0, 1'b0);
    lit("sw_wait_state", int'(snap.state), 5);
    cyc(1'b0, 6'h2b, 6'h00, 1'b0, 1'b0);
    lit("sw_rst_no_done", int'(snap.done), 0);
    cyc(1'b0, 6'h2b, 6'h00, 1'b0, 1'b0);
    lit("sw_rst_state", int'(snap.state), 15);
    lit("sw_rst_mem_write", int'(snap.mem_write), 0);
    cyc(1'b1, 6'h2b, 6'h00, 1'b0, 1'b1);

    cur_op = '0;
    cur_func = '0;
    repeat (4000) begin
      if (need_new || m_rst) begin
        case ($urandom_range(0, 3))
          0: begin cur_op = 6'h00; cur_func = fns[$urandom_range(0, 6)]; end
          1: begin cur_op = 6'h00; cur_func = 6'($urandom); end
          2: begin cur_op = 6'($urandom); cur_func = 6'($urandom); end
          default: begin cur_op = ops[$urandom_range(0, 7)]; cur_func = 6'($urandom); end
        endcase
      end
      cyc(($urandom_range(0, 63) != 0), cur_op, cur_func, 1'($urandom),
          ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
